// File: rtl/ervp_seq_mul_add_pkg.sv
// rtl/ervp_seq_mul_add_pkg.sv - shared state encoding and width helpers for the multiply-add engine
package ervp_seq_mul_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Product width is fixed by the operand widths so the final sum can never overflow.
    function automatic int bw_product(input int bw_multiplicand, input int bw_multiplier);
        return bw_multiplicand + bw_multiplier;
    endfunction

    // Number of bits needed to hold the unsigned value v (at least 1).
    function automatic int required_bitwidth_unsigned(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((v >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ervp_seq_mul_add_if.sv
// rtl/ervp_seq_mul_add_if.sv - operand/result handshake bundle for the multiply-add engine
interface ervp_seq_mul_add_if #(
    parameter int BW_MULTIPLICAND = 33,
    parameter int BW_MULTIPLIER   = 48
);
    localparam int BW_PRODUCT = BW_MULTIPLICAND + BW_MULTIPLIER;

    logic                       in_valid;
    logic                       in_ready;
    logic [BW_MULTIPLICAND-1:0] multiplicand;
    logic [BW_MULTIPLIER-1:0]   multiplier;
    logic [BW_MULTIPLICAND-1:0] addend;
    logic                       out_valid;
    logic                       out_ready;
    logic [BW_PRODUCT-1:0]      product;

    modport master (
        output in_valid, multiplicand, multiplier, addend, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, addend, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/ervp_seq_mul_add_datapath.sv
// rtl/ervp_seq_mul_add_datapath.sv - shift-add accumulator, operand registers and final adder
module ervp_seq_mul_add_datapath #(
    parameter int BW_MULTIPLICAND = 33,
    parameter int BW_MULTIPLIER   = 48
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       load,
    input  logic                                       mul_step,
    input  logic                                       add_step,
    input  logic [BW_MULTIPLICAND-1:0]                 multiplicand,
    input  logic [BW_MULTIPLIER-1:0]                   multiplier,
    input  logic [BW_MULTIPLICAND-1:0]                 addend,
    output logic [BW_MULTIPLICAND+BW_MULTIPLIER-1:0]   product
);
    localparam int A = BW_MULTIPLICAND;
    localparam int B = BW_MULTIPLIER;
    localparam int P = A + B;

    logic [A-1:0] mcand_q, mcand_d;
    logic [A-1:0] addend_q, addend_d;
    logic [A-1:0] acc_hi_q, acc_hi_d;
    logic [B-1:0] acc_lo_q, acc_lo_d;
    logic [P-1:0] product_q, product_d;

    logic [A:0]   partial;
    logic [P:0]   final_sum;

    // Upper-half adder keeps its carry so the right shift loses nothing.
    assign partial   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(A+1){1'b0}});
    assign final_sum = {1'b0, acc_hi_q, acc_lo_q} + (P+1)'(addend_q);

    // Next-state for operands, accumulator and result register.
    always_comb begin
        mcand_d   = mcand_q;
        addend_d  = addend_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        if (load) begin
            mcand_d  = multiplicand;
            addend_d = addend;
            acc_hi_d = '0;
            acc_lo_d = multiplier;
        end else if (mul_step) begin
            acc_hi_d = partial[A:1];
            acc_lo_d = {partial[0], acc_lo_q[B-1:1]};
        end
        if (add_step) begin
            product_d = final_sum[P-1:0];
        end
    end

    // Datapath registers; stall is applied upstream by gating the step strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            addend_q  <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            addend_q  <= addend_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
        end
    end

    // The final add can never carry out of the product width.
    always_ff @(posedge clk) begin
        if (!rst && add_step) begin
            assert (final_sum[P] == 1'b0);
        end
    end

    assign product = product_q;

endmodule

// File: rtl/ervp_seq_mul_add.sv
// rtl/ervp_seq_mul_add.sv - sequential unsigned multiply-add engine top with FSM and step counter
module ervp_seq_mul_add
    import ervp_seq_mul_add_pkg::*;
#(
    parameter int BW_MULTIPLICAND = 33,
    parameter int BW_MULTIPLIER   = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    ervp_seq_mul_add_if.slave    bus
);
    localparam int BW_PRODUCT = bw_product(BW_MULTIPLICAND, BW_MULTIPLIER);
    localparam int BW_CNT     = required_bitwidth_unsigned(BW_MULTIPLIER);
    localparam logic [BW_CNT-1:0] CNT_INIT = BW_CNT'(BW_MULTIPLIER);

    state_e             state_q, state_d;
    logic [BW_CNT-1:0]  cnt_q, cnt_d;
    logic               load;
    logic               mul_step;
    logic               add_step;
    logic [BW_PRODUCT-1:0] product;

    // Next-state, counter and step strobes; nothing moves while enable is low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        mul_step = 1'b0;
        add_step = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_MUL;
                    end
                end
                ST_MUL: begin
                    mul_step = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == BW_CNT'(1)) begin
                        state_d = ST_ADD;
                    end
                end
                ST_ADD: begin
                    add_step = 1'b1;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.product   = product;

    ervp_seq_mul_add_datapath #(
        .BW_MULTIPLICAND (BW_MULTIPLICAND),
        .BW_MULTIPLIER   (BW_MULTIPLIER)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .mul_step     (mul_step),
        .add_step     (add_step),
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
        .addend       (bus.addend),
        .product      (product)
    );

endmodule

// File: tb/tb_ervp_seq_mul_add.sv
// tb/tb_ervp_seq_mul_add.sv - self-checking bench for the sequential multiply-add engine
module tb_ervp_seq_mul_add;

    logic clk;
    logic rst;
    logic enable;

    int checks;
    int failures;

    logic [80:0] sb[$];

    ervp_seq_mul_add_if #(.BW_MULTIPLICAND(33), .BW_MULTIPLIER(48)) bus ();

    ervp_seq_mul_add #(
        .BW_MULTIPLICAND (33),
        .BW_MULTIPLIER   (48)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] a;
        logic [47:0] b;
        logic [32:0] c;
        logic [80:0] exp;
        string       name;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one operation, push its expected result, wait for the output and compare.
    task automatic op(input logic [32:0] a, input logic [47:0] b, input logic [32:0] c,
                      input logic [80:0] exp, input int exp_lat,
                      input int stall_at, input int stall_len, input string name);
        int n;
        logic [80:0] e;
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({name, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(exp);
        n = 1;
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.multiplicand = 33'($urandom());
        bus.multiplier   = 48'($urandom());
        bus.addend       = 33'($urandom());
        while (!bus.out_valid && n < 300) begin
            if (n == stall_at) enable = 1'b0;
            if (n == stall_at + stall_len) enable = 1'b1;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        enable = 1'b1;
        chk({name, "_out_valid"}, bus.out_valid, 1'b1);
        if (exp_lat >= 0) chk({name, "_latency"}, n, exp_lat);
        if (sb.size() == 0) begin
            chk({name, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({name, "_product"}, bus.product, e);
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_in_ready_after"}, bus.in_ready, 1'b1);
        chk({name, "_out_valid_after"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [80:0] d_big, q81, r81;
        logic [32:0] dv;
        logic [95:0] tmp;
        logic [80:0] held;
        int n;
        int seen;

        checks   = 0;
        failures = 0;

        vt[0] = '{33'd3, 48'd5, 33'd7, 81'd22, "basic"};
        vt[1] = '{{33{1'b1}}, {48{1'b1}}, {33{1'b1}}, {{33{1'b1}}, 48'h0}, "max"};
        vt[2] = '{33'd0, 48'd0, 33'h1_2345_6789, 81'h1_2345_6789, "zero_mult"};
        vt[3] = '{33'd1, 48'd1, 33'd0, 81'd1, "one"};
        vt[4] = '{33'h1_0000_0000, 48'h8000_0000_0000, 33'd0, (81'd1 << 79), "pow2"};
        vt[5] = '{33'd12345, 48'd678, 33'd9, 81'd8369919, "mixed"};

        rst              = 1'b1;
        enable           = 1'b1;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_product", bus.product, 81'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            op(vt[i].a, vt[i].b, vt[i].c, vt[i].exp, 50, -1, 0, vt[i].name);
        end

        // Enable dropped for 5 cycles in the middle of MUL.
        op(33'd1000, 48'd77777, 33'd3, 81'd77777003, 55, 10, 5, "stall");

        // Backpressure in DONE with a spurious in_valid.
        @(negedge clk);
        bus.multiplicand = 33'd11;
        bus.multiplier   = 48'd13;
        bus.addend       = 33'd17;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b0;
        @(posedge clk);
        sb.push_back(81'd160);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("bp_latency", n, 50);
        held = sb.pop_front();
        chk("bp_product", bus.product, held);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid     = 1'b1;
            bus.multiplicand = 33'($urandom());
            bus.multiplier   = 48'($urandom());
            bus.addend       = 33'($urandom());
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid_held", bus.out_valid, 1'b1);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
            chk("bp_product_stable", bus.product, 81'd160);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", bus.in_ready, 1'b1);
        chk("bp_out_valid_after", bus.out_valid, 1'b0);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("bp_ignored_in_valid", seen, 0);
        chk("bp_product_idle_hold", bus.product, 81'd160);

        // Reset in the middle of MUL discards the operation.
        @(negedge clk);
        bus.multiplicand = 33'd7;
        bus.multiplier   = 48'd9;
        bus.addend       = 33'd1;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        sb.push_back(81'd64);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (n < 21) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("rst_mid_busy", bus.in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_product", bus.product, 81'd0);
        sb.delete();
        op(33'd7, 48'd9, 33'd1, 81'd64, 50, -1, 0, "after_rst");

        // Divider round trip: feed (divisor, quotient, remainder), expect the dividend.
        for (int v = 0; v < 1000; v++) begin
            tmp = {$urandom(), $urandom(), $urandom()};
            if (v % 2 == 0) begin
                dv    = {1'b1, $urandom()};
                d_big = {1'b0, tmp[79:0]};
            end else begin
                dv = {1'b0, $urandom()} >> $urandom_range(0, 31);
                if (dv == 33'd0) dv = 33'd1;
                d_big = {33'd0, tmp[47:0]};
            end
            q81 = d_big / {48'd0, dv};
            r81 = d_big % {48'd0, dv};
            op(dv, q81[47:0], r81[32:0], d_big, 50, -1, 0, "roundtrip");
        end

        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
